// File: rtl/shift_src_mux_reg_pkg.sv
// Shared definitions for the shift-source select block: select-width helper,
// skid buffer depth and the buffer occupancy type.
package shift_src_mux_reg_pkg;

    localparam int SKID_DEPTH = 2;

    // Occupancy of the skid buffer, 0..SKID_DEPTH.
    typedef logic [1:0] skid_cnt_t;

    function automatic int fn_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_src_mux_reg_skid_buf2.sv
// Two-entry valid/ready skid buffer. in_ready depends only on the registered
// occupancy, so there is no combinational path from out_ready to in_ready.
module skid_buf2
    import shift_src_mux_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_cnt_t        r_count;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_count < skid_cnt_t'(SKID_DEPTH));
    assign out_valid = (r_count != skid_cnt_t'(0));
    assign out_data  = r_head;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // r_head is left untouched when the last word pops, so data_out keeps
    // showing the most recently popped word while the buffer is empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_count <= r_count + skid_cnt_t'(1);
                    if (r_count == skid_cnt_t'(0)) begin
                        r_head <= in_data;
                    end else begin
                        r_tail <= in_data;
                    end
                end
                2'b01: begin
                    r_count <= r_count - skid_cnt_t'(1);
                    if (r_count == skid_cnt_t'(2)) begin
                        r_head <= r_tail;
                    end
                end
                2'b11: begin
                    // Both only possible at count=1: the new word replaces the head.
                    r_head <= in_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_src_mux_reg.sv
// Registered N-way shift-source select with valid/ready flow control.
// Out-of-range selects are consumed, dropped and flagged on sticky sel_err.
module shift_src_mux_reg
    import shift_src_mux_reg_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_IN  = 3,
    localparam int SEL_W = fn_sel_w(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      data_out,
    output logic                  sel_err,
    input  logic                  err_clr
);

    localparam logic [SEL_W:0] N_IN_C = (SEL_W + 1)'(N_IN);

    logic [WIDTH-1:0] w_sel_word;
    logic             w_sel_ok;
    logic             w_accept;
    logic             w_bad;
    logic             w_buf_ready;
    logic             r_sel_err;

    // Extra MSB keeps the compare unsigned and valid when N_IN is a power of two.
    assign w_sel_ok = ({1'b0, sel} < N_IN_C);

    always_comb begin
        w_sel_word = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_word = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = w_buf_ready;
    assign w_accept = in_valid & w_buf_ready;
    assign w_bad    = w_accept & ~w_sel_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_err <= 1'b0;
        end else if (w_bad) begin
            r_sel_err <= 1'b1;
        end else if (err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

    assign sel_err = r_sel_err;

    skid_buf2 #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid & w_sel_ok),
        .in_ready (w_buf_ready),
        .in_data  (w_sel_word),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (data_out)
    );

endmodule
